// File: rtl/bus_ram.sv
// Word RAM on the shared tri-state datapath bus: address latch, bus write, registered read-drive.
// Optional feature macro: WRITE_PROTECT_EN (drops writes below PROTECT_TOP and flags err).
module bus_ram #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int PROTECT_TOP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_ld,
  input  logic              write,
  input  logic              read,
  input  logic              inc,
  inout  logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              err,
  output logic [ADDR_W-1:0] addr
);

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  localparam logic [ADDR_W:0] LP_TOP = (ADDR_W+1)'(PROTECT_TOP);
`ifdef WRITE_PROTECT_EN
  localparam logic LP_WP_EN = 1'b1;
`else
  localparam logic LP_WP_EN = 1'b0;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic              r_err;
  logic              w_err_nxt;
  logic              w_mem_we;
  logic              w_dout_ld;
  logic              w_valid;
  logic              w_multi;
  logic              w_wp_block;
  logic [1:0]        w_n_strb;

  assign w_n_strb   = {1'b0, addr_ld} + {1'b0, write} + {1'b0, read};
  assign w_multi    = (w_n_strb > 2'd1);
  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign w_wp_block = LP_WP_EN & ({1'b0, r_addr} < LP_TOP);

  // Bus is released combinationally the moment read drops or a conflicting strobe appears.
  assign w_valid = (r_state == S_DRIVE) & read & ~write & ~addr_ld;
  assign valid   = w_valid;
  assign data    = w_valid ? r_dout : 'z;
  assign err     = r_err;
  assign addr    = r_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_mem_we    = 1'b0;
    w_dout_ld   = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_multi) begin
          w_err_nxt = 1'b1;
        end else if (addr_ld) begin
          w_addr_nxt = data[ADDR_W-1:0];
        end else if (write) begin
          if (w_wp_block) begin
            w_err_nxt = 1'b1;
          end else begin
            w_mem_we = 1'b1;
            if (inc) w_addr_nxt = w_addr_inc;
          end
        end else if (read) begin
          w_dout_ld   = 1'b1;
          w_state_nxt = S_DRIVE;
          if (inc) w_addr_nxt = w_addr_inc;
        end
      end
      S_DRIVE: begin
        if (write || addr_ld) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!read) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_dout  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_err   <= w_err_nxt;
      if (w_dout_ld) r_dout <= r_mem[r_addr];
    end
  end

  // Storage has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we && rst) r_mem[r_addr] <= data;
  end

endmodule

// File: tb/tb_bus_ram.sv
// Directed bench for bus_ram: reset, write/read-drive timing, address wrap, conflicts, protection.
module tb_bus_ram;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 8;
  localparam int PROTECT_TOP = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              addr_ld = 1'b0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic              inc = 1'b0;
  logic              valid;
  logic              err;
  logic [ADDR_W-1:0] addr;
  logic              r_drv_en = 1'b0;
  logic [DATA_W-1:0] r_drv = '0;
  wire  [DATA_W-1:0] w_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  assign w_data = r_drv_en ? r_drv : 'z;

  bus_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROTECT_TOP(PROTECT_TOP)) u_dut (
    .clk(clk), .rst(rst), .addr_ld(addr_ld), .write(write), .read(read), .inc(inc),
    .data(w_data), .valid(valid), .err(err), .addr(addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ld, input logic wr, input logic rd, input logic in,
                        input logic en, input logic [DATA_W-1:0] v);
    addr_ld  = ld;
    write    = wr;
    read     = rd;
    inc      = in;
    r_drv_en = en;
    r_drv    = v;
  endtask

  initial begin
    #3;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    #9 rst = 1'b1;

    // write 42 at 37, read it back with one-cycle latency
    set_in(1, 0, 0, 0, 1, 16'd37); step();
    check("ld_addr", 32'(addr), 32'd37);
    set_in(0, 1, 0, 0, 1, 16'd42); step();
    check("wr_noinc_addr", 32'(addr), 32'd37);
    check("wr_err", 32'(err), 32'd0);
    set_in(1, 0, 0, 0, 1, 16'd37); step();
    set_in(0, 0, 1, 0, 0, 16'd0); #1;
    check("rd_lat0_valid", 32'(valid), 32'd0);
    step();
    check("rd_c1_valid", 32'(valid), 32'd1);
    check("rd_c1_data", 32'(w_data), 32'd42);
    step();
    check("rd_c2_data", 32'(w_data), 32'd42);
    step();
    check("rd_c3_data", 32'(w_data), 32'd42);
    read = 1'b0; #1;
    check("rd_release", 32'(valid), 32'd0);
    step();
    check("rd_idle_valid", 32'(valid), 32'd0);

    // wrap at top of address space
    set_in(1, 0, 0, 0, 1, 16'd255); step();
    check("ld_255", 32'(addr), 32'd255);
    set_in(0, 1, 0, 1, 1, 16'd7); step();
    check("wr_wrap_addr", 32'(addr), 32'd0);
    check("wr_wrap_err", 32'(err), 32'd0);
    set_in(1, 0, 0, 0, 1, 16'd255); step();
    set_in(0, 0, 1, 1, 0, 16'd0); step();
    check("rd255_data", 32'(w_data), 32'd7);
    check("rd255_addr", 32'(addr), 32'd0);
    set_in(0, 0, 0, 0, 0, 16'd0); step();
    set_in(0, 0, 1, 1, 0, 16'd0); step();
    check("rd_inc_addr", 32'(addr), 32'd1);
    check("rd_inc_valid", 32'(valid), 32'd1);
    set_in(0, 0, 0, 0, 0, 16'd0); step();

    // read+write together in IDLE
    set_in(1, 0, 0, 0, 1, 16'd37); step();
    set_in(0, 1, 1, 0, 1, 16'd99); step();
    check("conf_err", 32'(err), 32'd1);
    check("conf_addr", 32'(addr), 32'd37);
    check("conf_valid", 32'(valid), 32'd0);
    set_in(0, 0, 0, 0, 0, 16'd0); step();
    check("conf_err_pulse", 32'(err), 32'd0);
    set_in(0, 0, 1, 0, 0, 16'd0); step();
    check("conf_mem", 32'(w_data), 32'd42);

    // addr_ld while driving
    set_in(1, 0, 1, 0, 1, 16'd77); #1;
    check("drv_ld_release", 32'(valid), 32'd0);
    check("drv_ld_bus", 32'(w_data), 32'd77);
    step();
    check("drv_ld_err", 32'(err), 32'd1);
    check("drv_ld_addr", 32'(addr), 32'd37);
    set_in(0, 0, 0, 0, 0, 16'd0); step();
    check("drv_ld_err_pulse", 32'(err), 32'd0);
    set_in(0, 0, 1, 0, 0, 16'd0); step();
    check("drv_ld_idle_rd", 32'(w_data), 32'd42);

    // async reset in the middle of a read
    rst = 1'b0; #1;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_addr", 32'(addr), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    read = 1'b0; #1;
    rst = 1'b1;
    step();
    set_in(1, 0, 0, 0, 1, 16'd37); step();
    set_in(0, 0, 1, 0, 0, 16'd0); step();
    check("rst_mem_kept", 32'(w_data), 32'd42);
    set_in(0, 0, 0, 0, 0, 16'd0); step();

    // write protection boundary
    set_in(1, 0, 0, 0, 1, 16'd4); step();
    set_in(0, 1, 0, 1, 1, 16'd3); step();
`ifdef WRITE_PROTECT_EN
    check("wp_lo_err", 32'(err), 32'd1);
    check("wp_lo_addr", 32'(addr), 32'd4);
`else
    check("wp_lo_err", 32'(err), 32'd0);
    check("wp_lo_addr", 32'(addr), 32'd5);
    set_in(1, 0, 0, 0, 1, 16'd4); step();
    set_in(0, 0, 1, 0, 0, 16'd0); step();
    check("wp_lo_mem", 32'(w_data), 32'd3);
`endif
    set_in(1, 0, 0, 0, 1, 16'd16); step();
    set_in(0, 1, 0, 0, 1, 16'd3); step();
    check("wp_hi_err", 32'(err), 32'd0);
    set_in(0, 0, 1, 0, 0, 16'd0); step();
    check("wp_hi_mem", 32'(w_data), 32'd3);
    set_in(0, 0, 0, 0, 0, 16'd0); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
